// File: rtl/wb_master_engine_if.sv
// Signal bundle between the command/response client, wb_master_engine and the Wishbone slave.
// Port names keep their original _i/_o suffixes for drop-in compatibility.
interface wb_master_engine_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned GRANULE    = 8
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULE;

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [1:0]            cmd_op_i;
  logic [ADDR_WIDTH-1:0] cmd_adr_i;
  logic [SEL_WIDTH-1:0]  cmd_sel_i;
  logic [DATA_WIDTH-1:0] cmd_dat_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_dat_o;
  logic                  rsp_err_o;

  logic [ADDR_WIDTH-1:0] adr_o;
  logic [SEL_WIDTH-1:0]  sel_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  we_o;
  logic                  cyc_o;
  logic                  stb_o;
  logic [DATA_WIDTH-1:0] dat_i;
  logic                  ack_i;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_sel_i, cmd_dat_i, rsp_ready_i, dat_i, ack_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    output adr_o, sel_o, dat_o, we_o, cyc_o, stb_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_sel_i, cmd_dat_i, rsp_ready_i, dat_i, ack_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  adr_o, sel_o, dat_o, we_o, cyc_o, stb_o
  );
endinterface

// File: rtl/wb_master_engine.sv
// Wishbone classic-cycle initiator: read, write and read-modify-write with a wait-state timeout.
// Every output is a register loaded from the next-state decode, so no input reaches an output combinationally.
module wb_master_engine #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned GRANULE    = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_master_engine_if.master bus
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULE;
  localparam int unsigned CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, RD, GAP, WR, RESP} state_t;

  state_t                state, state_n;
  logic [1:0]            op_q, op_n;
  logic [ADDR_WIDTH-1:0] adr_q, adr_n;
  logic [SEL_WIDTH-1:0]  sel_q, sel_n;
  logic [DATA_WIDTH-1:0] dat_q, dat_n;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_n;
  logic                  err_q, err_n;
  logic                  ready_q, valid_q, cyc_q, stb_q, we_q;
  logic [CNT_W-1:0]      cnt;
  logic                  timed_out;
  logic                  bus_phase;

  assign bus_phase = (state == RD) || (state == WR);
  assign timed_out = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));

  always_comb begin
    state_n = state;
    op_n    = op_q;
    adr_n   = adr_q;
    sel_n   = sel_q;
    dat_n   = dat_q;
    rdat_n  = rdat_q;
    err_n   = err_q;
    case (state)
      IDLE: begin
        if (ready_q && bus.cmd_valid_i) begin
          op_n   = bus.cmd_op_i;
          adr_n  = bus.cmd_adr_i;
          sel_n  = bus.cmd_sel_i;
          dat_n  = bus.cmd_dat_i;
          rdat_n = '0;
          err_n  = 1'b0;
          case (bus.cmd_op_i)
            2'd0, 2'd2: state_n = RD;
            2'd1:       state_n = WR;
            default: begin
              state_n = RESP;
              err_n   = 1'b1;
            end
          endcase
        end
      end
      RD: begin
        if (bus.ack_i) begin
          rdat_n  = bus.dat_i;
          state_n = (op_q == 2'd2) ? GAP : RESP;
        end else if (timed_out) begin
          // A read-phase timeout abandons an RMW before its write phase.
          rdat_n  = '0;
          err_n   = 1'b1;
          state_n = RESP;
        end
      end
      GAP: state_n = WR;
      WR: begin
        if (bus.ack_i) begin
          state_n = RESP;
        end else if (timed_out) begin
          rdat_n  = '0;
          err_n   = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      op_q    <= '0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      op_q    <= op_n;
      adr_q   <= adr_n;
      sel_q   <= sel_n;
      dat_q   <= dat_n;
      rdat_q  <= rdat_n;
      err_q   <= err_n;
      ready_q <= (state_n == IDLE);
      valid_q <= (state_n == RESP);
      cyc_q   <= (state_n == RD) || (state_n == GAP) || (state_n == WR);
      stb_q   <= (state_n == RD) || (state_n == WR);
      we_q    <= (state_n == WR);
      // Cleared outside the strobe phases, so entry into RD or WR always starts from zero.
      if (bus_phase && !bus.ack_i) cnt <= cnt + CNT_W'(1);
      else                         cnt <= '0;
    end
  end

  assign bus.cmd_ready_o = ready_q;
  assign bus.rsp_valid_o = valid_q;
  assign bus.rsp_dat_o   = rdat_q;
  assign bus.rsp_err_o   = err_q;
  assign bus.adr_o       = adr_q;
  assign bus.sel_o       = sel_q;
  assign bus.dat_o       = dat_q;
  assign bus.we_o        = we_q;
  assign bus.cyc_o       = cyc_q;
  assign bus.stb_o       = stb_q;
endmodule

// File: tb/tb_wb_master_engine.sv
// Directed-vector bench for wb_master_engine against a small Wishbone register-file slave model.
// Everything is driven and sampled on the falling clock edge.
module tb_wb_master_engine;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  wb_master_engine_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .GRANULE(8)) bus ();

  wb_master_engine #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .GRANULE(8),
    .TIMEOUT(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus)
  );

  int          ws = 0;
  bit          noack = 1'b0;
  bit          stray = 1'b0;
  int          wcnt;
  logic [31:0] mem [16];

  // Slave model shares the reset and reloads its preload image on every reset.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[2] <= 32'hCAFE_F00D;
      mem[4] <= 32'h1111_1111;
      wcnt   <= 0;
    end else begin
      if (bus.stb_o && !bus.ack_i) wcnt <= wcnt + 1;
      else                         wcnt <= 0;
      if (bus.stb_o && bus.we_o && bus.ack_i)
        for (int b = 0; b < 4; b++)
          if (bus.sel_o[b]) mem[bus.adr_o[5:2]][8*b +: 8] <= bus.dat_o[8*b +: 8];
    end
  end

  always_comb begin
    bus.ack_i = stray || (bus.stb_o && !noack && (wcnt == ws));
    bus.dat_i = mem[bus.adr_o[5:2]];
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    string       tag;
    logic [1:0]  op;
    logic [15:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          ws;
    bit          noack;
    int          hold;
    logic [31:0] e_dat;
    bit          e_err;
    logic [15:0] e_stb;
    logic [15:0] e_cyc;
    logic [15:0] e_we;
    int          e_lat;
  } vec_t;

  function automatic vec_t mk(string tag, logic [1:0] op, logic [15:0] adr, logic [3:0] sel,
                              logic [31:0] dat, int w, bit na, int hold, logic [31:0] e_dat,
                              bit e_err, logic [15:0] e_stb, logic [15:0] e_cyc,
                              logic [15:0] e_we, int e_lat);
    vec_t v;
    v.tag = tag; v.op = op; v.adr = adr; v.sel = sel; v.dat = dat; v.ws = w; v.noack = na;
    v.hold = hold; v.e_dat = e_dat; v.e_err = e_err; v.e_stb = e_stb; v.e_cyc = e_cyc;
    v.e_we = e_we; v.e_lat = e_lat;
    return v;
  endfunction

  // Per-cycle stb/cyc/we bits are shifted in oldest-first until the response appears.
  task automatic run_vec(input vec_t v);
    int          lat;
    int          bad;
    bit          seen;
    logic [15:0] sp, cp, wp;
    ws = v.ws;
    noack = v.noack;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.cmd_ready_o) seen = 1'b1;
      else @(negedge clk_i);
    end
    check({v.tag, "_ready"}, 32'(seen), 32'd1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = v.op;
    bus.cmd_adr_i   = v.adr;
    bus.cmd_sel_i   = v.sel;
    bus.cmd_dat_i   = v.dat;
    @(negedge clk_i);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_dat_i   = 32'h0;
    lat = 1; bad = 0; seen = 1'b0; sp = '0; cp = '0; wp = '0;
    while (!seen && lat < 40) begin
      if (bus.rsp_valid_o) begin
        seen = 1'b1;
      end else begin
        sp = {sp[14:0], bus.stb_o};
        cp = {cp[14:0], bus.cyc_o};
        wp = {wp[14:0], bus.we_o};
        if (bus.cyc_o && (bus.adr_o !== v.adr || bus.sel_o !== v.sel ||
                          (bus.we_o && bus.dat_o !== v.dat))) bad++;
        @(negedge clk_i);
        lat++;
      end
    end
    check({v.tag, "_rsp_seen"}, 32'(seen), 32'd1);
    check({v.tag, "_latency"}, 32'(lat), 32'(v.e_lat));
    check({v.tag, "_stb_pat"}, 32'(sp), 32'(v.e_stb));
    check({v.tag, "_cyc_pat"}, 32'(cp), 32'(v.e_cyc));
    check({v.tag, "_we_pat"}, 32'(wp), 32'(v.e_we));
    check({v.tag, "_bus_fields_bad"}, 32'(bad), 32'd0);
    check({v.tag, "_rsp_dat"}, bus.rsp_dat_o, v.e_dat);
    check({v.tag, "_rsp_err"}, 32'(bus.rsp_err_o), 32'(v.e_err));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk_i);
      check({v.tag, "_hold_valid"}, 32'(bus.rsp_valid_o), 32'd1);
      check({v.tag, "_hold_dat"}, bus.rsp_dat_o, v.e_dat);
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk_i);
    bus.rsp_ready_i = 1'b0;
    check({v.tag, "_valid_drop"}, 32'(bus.rsp_valid_o), 32'd0);
    check({v.tag, "_ready_back"}, 32'(bus.cmd_ready_o), 32'd1);
  endtask

  vec_t vq[$];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = 2'd0;
    bus.cmd_adr_i   = 16'h0;
    bus.cmd_sel_i   = 4'h0;
    bus.cmd_dat_i   = 32'h0;
    bus.rsp_ready_i = 1'b0;

    //        tag          op    adr       sel   dat            ws na hold e_dat          err stb       cyc       we        lat
    vq.push_back(mk("wr0",     2'd1, 16'h0004, 4'hF, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 16'h1,    16'h1,    16'h1,    2));
    vq.push_back(mk("rd_ws2",  2'd0, 16'h0004, 4'hF, 32'h0,        2, 0, 4, 32'hDEADBEEF, 0, 16'h7,    16'h7,    16'h0,    4));
    vq.push_back(mk("rmw0",    2'd2, 16'h0008, 4'hF, 32'h12345678, 0, 0, 0, 32'hCAFEF00D, 0, 16'h5,    16'h7,    16'h1,    4));
    vq.push_back(mk("rd_rmw",  2'd0, 16'h0008, 4'hF, 32'h0,        1, 0, 0, 32'h12345678, 0, 16'h3,    16'h3,    16'h0,    3));
    vq.push_back(mk("wr_half", 2'd1, 16'h000C, 4'h3, 32'hAAAA5555, 0, 0, 0, 32'h0,        0, 16'h1,    16'h1,    16'h1,    2));
    vq.push_back(mk("rd_half", 2'd0, 16'h000C, 4'hF, 32'h0,        0, 0, 0, 32'h00005555, 0, 16'h1,    16'h1,    16'h0,    2));
    vq.push_back(mk("rd_to",   2'd0, 16'h0004, 4'hF, 32'h0,        0, 1, 0, 32'h0,        1, 16'h1F,   16'h1F,   16'h0,    6));
    vq.push_back(mk("rmw_to",  2'd2, 16'h0010, 4'hF, 32'h5A5A5A5A, 0, 1, 0, 32'h0,        1, 16'h1F,   16'h1F,   16'h0,    6));
    vq.push_back(mk("op3",     2'd3, 16'h0004, 4'hF, 32'h0,        0, 0, 2, 32'h0,        1, 16'h0,    16'h0,    16'h0,    1));
    vq.push_back(mk("rmw_ws1", 2'd2, 16'h0010, 4'hF, 32'h22222222, 1, 0, 0, 32'h11111111, 0, 16'h1B,   16'h1F,   16'h3,    6));
    vq.push_back(mk("rd_rmw2", 2'd0, 16'h0010, 4'hF, 32'h0,        0, 0, 0, 32'h22222222, 0, 16'h1,    16'h1,    16'h0,    2));

    // Reset state and first ready edge.
    repeat (3) @(negedge clk_i);
    check("rst_cyc", 32'(bus.cyc_o), 32'd0);
    check("rst_stb", 32'(bus.stb_o), 32'd0);
    check("rst_ready", 32'(bus.cmd_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    rst_i = 1'b1;
    #1 check("release_ready_before_edge", 32'(bus.cmd_ready_o), 32'd0);
    @(negedge clk_i);
    check("release_ready_after_edge", 32'(bus.cmd_ready_o), 32'd1);

    foreach (vq[i]) run_vec(vq[i]);

    // Stray ack while idle must not start anything.
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("stray_cyc", 32'(bus.cyc_o), 32'd0);
      check("stray_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      check("stray_ready", 32'(bus.cmd_ready_o), 32'd1);
    end
    stray = 1'b0;
    @(negedge clk_i);
    run_vec(mk("rd_after_stray", 2'd0, 16'h0004, 4'hF, 32'h0, 0, 0, 0, 32'hDEADBEEF, 0,
               16'h1, 16'h1, 16'h0, 2));

    // Asynchronous reset during the read wait of an RMW.
    noack = 1'b1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = 2'd2;
    bus.cmd_adr_i   = 16'h0008;
    bus.cmd_sel_i   = 4'hF;
    bus.cmd_dat_i   = 32'h99999999;
    @(negedge clk_i);
    bus.cmd_valid_i = 1'b0;
    @(negedge clk_i);
    check("mid_rmw_stb", 32'(bus.stb_o), 32'd1);
    check("mid_rmw_cyc", 32'(bus.cyc_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    check("async_cyc", 32'(bus.cyc_o), 32'd0);
    check("async_stb", 32'(bus.stb_o), 32'd0);
    check("async_adr", 32'(bus.adr_o), 32'd0);
    check("async_dat", bus.dat_o, 32'd0);
    check("async_ready", 32'(bus.cmd_ready_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    noack = 1'b0;
    @(negedge clk_i);
    check("post_rst_ready", 32'(bus.cmd_ready_o), 32'd1);
    run_vec(mk("rd_post_rst", 2'd0, 16'h0008, 4'hF, 32'h0, 0, 0, 0, 32'hCAFEF00D, 0,
               16'h1, 16'h1, 16'h0, 2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
